registrador_deslocamento_universal: RTL

//  Parametrised universal shift register. Generalises the fixed 4-bit serial-in register.
//  - WIDTH is configurable.
//  - Four modes: hold, shift right, shift left, parallel load.
//  - Clock enable.
//  - Shift counter that flags each completed serial word.

---
 rtl/registrador_pkg.sv | 9 +
 rtl/contador_palavra.sv | 36 +++
 rtl/registrador_deslocamento_universal.sv | 55 +++++
 3 files changed

// File: rtl/registrador_pkg.sv
// Shared mode encoding for the universal shift register and its bench.
package registrador_pkg;

    localparam logic [1:0] MODO_HOLD  = 2'b00;
    localparam logic [1:0] MODO_DIR   = 2'b01;
    localparam logic [1:0] MODO_ESQ   = 2'b10;
    localparam logic [1:0] MODO_CARGA = 2'b11;

endpackage

// File: rtl/contador_palavra.sv
// Counts serial shifts and pulses WordReady on each completed word.
module contador_palavra #(
    parameter int WIDTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Step,
    input  logic                     Clear,
    output logic [$clog2(WIDTH)-1:0] Count,
    output logic                     WordReady
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(WIDTH - 1);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Count     <= '0;
            WordReady <= 1'b0;
        end else if (Clear) begin
            Count     <= '0;
            WordReady <= 1'b0;
        end else if (Step) begin
            if (Count == ULTIMO) begin
                Count     <= '0;
                WordReady <= 1'b1;
            end else begin
                Count     <= Count + 1'b1;
                WordReady <= 1'b0;
            end
        end else begin
            WordReady <= 1'b0;
        end
    end

endmodule

// File: rtl/registrador_deslocamento_universal.sv
// Parametrised universal shift register: hold, shift right/left, load,
// with a word counter for serial<->parallel conversion.
module registrador_deslocamento_universal
    import registrador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Enable,
    input  logic [1:0]               Mode,
    input  logic                     SerialInR,
    input  logic                     SerialInL,
    input  logic [WIDTH-1:0]         Data,
    output logic [WIDTH-1:0]         Q,
    output logic                     SerialOutR,
    output logic                     SerialOutL,
    output logic [$clog2(WIDTH)-1:0] Count,
    output logic                     WordReady
);

    logic step;
    logic clear;

    assign step  = Enable & (Mode[0] ^ Mode[1]);
    assign clear = Enable & (Mode == MODO_CARGA);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= '0;
        end else if (Enable) begin
            unique case (Mode)
                MODO_HOLD:  Q <= Q;
                MODO_DIR:   Q <= {SerialInR, Q[WIDTH-1:1]};
                MODO_ESQ:   Q <= {Q[WIDTH-2:0], SerialInL};
                MODO_CARGA: Q <= Data;
            endcase
        end
    end

    assign SerialOutR = Q[0];
    assign SerialOutL = Q[WIDTH-1];

    contador_palavra #(
        .WIDTH(WIDTH)
    ) u_contador (
        .Clock    (Clock),
        .Reset    (Reset),
        .Step     (step),
        .Clear    (clear),
        .Count    (Count),
        .WordReady(WordReady)
    );

endmodule
